// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU and W variants).
// Restoring shift-subtract datapath, one quotient bit per cycle, start/busy/done handshake.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      func_i,
  input  logic            word_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] s_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          state_q, state_d;
  logic            prep_q, prep_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      func_q, func_d;
  logic            word_q, word_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] s_q, s_d;
  logic            done_q, done_d;

  // Start-side decode on the raw request.
  logic sgn_op, sa_i, sb_i, b_zero, ovf;
  assign sgn_op = ~func_i[0];
  assign sa_i   = word_i ? a_i[31] : a_i[63];
  assign sb_i   = word_i ? b_i[31] : b_i[63];
  assign b_zero = word_i ? (b_i[31:0] == 32'd0) : (b_i == '0);
  assign ovf    = sgn_op & (word_i ? ((a_i[31:0] == 32'h8000_0000) && (&b_i[31:0]))
                                   : ((a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i)));

  // Operands are latched raw and turned into magnitudes one cycle later, keeping the
  // negation off the start path. Word dividends sit in the top half so that 32 shifts
  // leave the quotient in the low half.
  logic            sgn_q;
  logic [XLEN-1:0] mag_a, mag_b;
  assign sgn_q = ~func_q[0];
  assign mag_a = word_q ? {((sgn_q & quo_q[31]) ? -quo_q[31:0] : quo_q[31:0]), 32'd0}
                        : ((sgn_q & quo_q[63]) ? -quo_q : quo_q);
  assign mag_b = word_q ? {32'd0, ((sgn_q & div_q[31]) ? -div_q[31:0] : div_q[31:0])}
                        : ((sgn_q & div_q[63]) ? -div_q : div_q);

  // rem < divisor always holds, so bit XLEN of the trial is a valid sign bit.
  logic [XLEN:0] rem_shift, trial;
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, div_q};

  logic [XLEN-1:0] q_fix, r_fix, res;
  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;
  assign res   = func_q[1] ? r_fix : q_fix;

  always_comb begin
    state_d = state_q;
    prep_d  = prep_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    word_d  = word_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    s_d     = s_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          func_d  = func_i;
          word_d  = word_i;
          state_d = StFix;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          if (b_zero) begin
            quo_d = '1;
            rem_d = a_i;
          end else if (ovf) begin
            quo_d = a_i;
            rem_d = '0;
          end else begin
            quo_d   = a_i;
            div_d   = b_i;
            rem_d   = '0;
            negq_d  = sgn_op & (sa_i ^ sb_i);
            negr_d  = sgn_op & sa_i;
            cnt_d   = word_i ? 6'd31 : 6'd63;
            prep_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (prep_q) begin
          quo_d  = mag_a;
          div_d  = mag_b;
          prep_d = 1'b0;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
          rem_d = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) state_d = StFix;
        end
      end
      StFix: begin
        s_d     = word_q ? {{32{res[31]}}, res[31:0]} : res;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prep_q  <= 1'b0;
      cnt_q   <= '0;
      func_q  <= '0;
      word_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prep_q  <= prep_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      word_q  <= word_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign s_o    = s_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, handshake/reset sequences and random
// operations checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic [1:0]  func_i = '0;
  logic        word_i = 1'b0;
  logic        busy_o, done_o;
  logic [63:0] s_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_unit #(.XLEN(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .func_i (func_i),
    .word_i (word_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .s_o    (s_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] f, input logic w);
    logic [31:0] r32;
    logic [63:0] r64;
    int          sx, sy;
    longint      lx, ly;
    logic [31:0] ux, uy;
    if (w) begin
      ux = a[31:0];
      uy = b[31:0];
      sx = a[31:0];
      sy = b[31:0];
      if (!f[0]) begin
        if (sy == 0)                           r32 = f[1] ? ux : 32'hFFFF_FFFF;
        else if (ux == 32'h8000_0000 && sy == -1) r32 = f[1] ? 32'd0 : ux;
        else                                   r32 = f[1] ? sx % sy : sx / sy;
      end else begin
        if (uy == 0) r32 = f[1] ? ux : 32'hFFFF_FFFF;
        else         r32 = f[1] ? ux % uy : ux / uy;
      end
      return {{32{r32[31]}}, r32};
    end
    lx = a;
    ly = b;
    if (!f[0]) begin
      if (b == 0)                                       r64 = f[1] ? a : '1;
      else if (a == 64'h8000_0000_0000_0000 && ly == -1) r64 = f[1] ? 64'd0 : a;
      else                                              r64 = f[1] ? lx % ly : lx / ly;
    end else begin
      if (b == 0) r64 = f[1] ? a : '1;
      else        r64 = f[1] ? a % b : a / b;
    end
    return r64;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] f, input logic w);
    bit zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return w ? 34 : 66;
  endfunction

  // Called at #1 after an edge; start is sampled at the next rising edge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                        input logic w, output logic [63:0] res, output int lat,
                        output int bcnt);
    a_i = a; b_i = b; func_i = f; word_i = w; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    bcnt = busy_o ? 1 : 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done_o && busy_o) bcnt++;
    end while (!done_o && lat < 200);
    res = s_o;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  f;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] res, a, b;
    logic [1:0]  f;
    logic        w;
    int          lat, bcnt, done_seen, sel;

    vecs[0]  = '{64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 66};
    vecs[1]  = '{64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 66};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[4]  = '{64'd5, 64'd0, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{64'd5, 64'd0, 2'b11, 1'b0, 64'd5, 1};
    vecs[6]  = '{64'h1234_5678_8000_0000, 64'd0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
                 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b10, 1'b1, 64'd0, 1};
    vecs[9]  = '{64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[10] = '{64'h0000_0000_FFFF_FFFE, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 34};

    #3;
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_done", {63'd0, done_o}, 64'd0);
    check("reset_s", s_o, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; each result must also hold for a cycle with done back low.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].w, res, lat, bcnt);
      check($sformatf("vec%0d_s", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {63'd0, done_o}, 64'd0);
      check($sformatf("vec%0d_hold", i), s_o, vecs[i].exp);
    end

    // Start while busy (with changed operands) is ignored.
    a_i = 64'd1000; b_i = 64'd7; func_i = 2'b01; word_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) begin
        start_i = 1'b1; a_i = 64'd5; b_i = 64'd0; func_i = 2'b00;
      end else begin
        start_i = 1'b0;
      end
    end while (!done_o && lat < 200);
    check("busy_start_s", s_o, 64'd142);
    check("busy_start_lat", 64'(lat), 64'd66);
    @(posedge clk); #1;
    check("busy_start_no_extra", {62'd0, busy_o, done_o}, 64'd0);

    // Asynchronous reset mid-operation discards it.
    a_i = 64'd1000; b_i = 64'd7; func_i = 2'b11; word_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_s", s_o, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) done_seen++;
    end
    check("rst_no_done", 64'(done_seen), 64'd0);
    run_op(64'd1000, 64'd7, 2'b11, 1'b0, res, lat, bcnt);
    check("after_rst_s", res, 64'd6);
    check("after_rst_lat", 64'(lat), 64'd66);

    // Random ops issued back to back, so each start lands in the previous done cycle.
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = {$urandom, 32'd0} & (w ? 64'hFFFF_FFFF_0000_0000 : 64'd0);
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: b = {$urandom, $urandom} >> $urandom_range(1, 60);
        default: b = {$urandom, $urandom};
      endcase
      run_op(a, b, f, w, res, lat, bcnt);
      check($sformatf("rnd%0d_s a=%h b=%h f=%0d w=%0d", i, a, b, f, w), res,
            ref_model(a, b, f, w));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_lat(a, b, f, w)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
